// File: rtl/count_axil_txn_master.sv
// rtl/count_axil_txn_master.sv - AXI4-Lite master for counter write-back and start-value fetch
// Optional watchdog on every handshake state: define TXN_TIMEOUT_EN.
module count_axil_txn_master #(
    parameter int          COUNT_W        = 8,
    parameter logic [31:0] WR_ADDR        = 32'h0000_0200,
    parameter logic [31:0] RD_ADDR        = 32'h0000_0204,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic               aclk,
    input  logic               areset,
    input  logic               init_write,
    input  logic               init_read,
    input  logic [COUNT_W-1:0] count_in,
    output logic [COUNT_W-1:0] start_value,
    output logic               start_load,
    output logic               txn_done,
    output logic               txn_error,
    output logic [31:0]        m_axi_awaddr,
    output logic [2:0]         m_axi_awprot,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,
    output logic [31:0]        m_axi_wdata,
    output logic [3:0]         m_axi_wstrb,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    input  logic [1:0]         m_axi_bresp,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready,
    output logic [31:0]        m_axi_araddr,
    output logic [2:0]         m_axi_arprot,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [31:0]        m_axi_rdata,
    input  logic [1:0]         m_axi_rresp,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE} state_t;

    state_t state;
    logic   pend_wr;
    logic   pend_rd;
    logic   aw_done;
    logic   w_done;
    logic   aw_hs;
    logic   w_hs;
    logic   unused_rdata_hi;

    assign m_axi_awaddr = WR_ADDR;
    assign m_axi_araddr = RD_ADDR;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;
    assign m_axi_wstrb  = 4'hF;

    assign aw_hs = m_axi_awvalid && m_axi_awready;
    assign w_hs  = m_axi_wvalid && m_axi_wready;
    assign unused_rdata_hi = ^m_axi_rdata[31:COUNT_W];

`ifdef TXN_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t          state_q;
    logic [WD_W-1:0] wdog;
    logic [WD_W-1:0] spent;
    logic            wd_active;
    logic            timeout;

    // spent = cycles including the current one that the FSM has sat in this state
    assign wd_active = (state == WR_REQ) || (state == WR_RESP) ||
                       (state == RD_REQ) || (state == RD_RESP);
    assign spent     = (state != state_q) ? WD_W'(1) : wdog + WD_W'(1);
    assign timeout   = wd_active && (spent == WD_W'(TIMEOUT_CYCLES));

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= IDLE;
            wdog    <= '0;
        end else begin
            state_q <= state;
            wdog    <= wd_active ? spent : '0;
        end
    end
`endif

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= IDLE;
            pend_wr       <= 1'b0;
            pend_rd       <= 1'b0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
            m_axi_awvalid <= 1'b0;
            m_axi_wvalid  <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_bready  <= 1'b0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            start_value   <= '0;
            start_load    <= 1'b0;
            txn_done      <= 1'b0;
            txn_error     <= 1'b0;
        end else begin
            txn_done   <= 1'b0;
            start_load <= 1'b0;
            pend_wr    <= pend_wr | init_write;
            pend_rd    <= pend_rd | init_read;
`ifdef TXN_TIMEOUT_EN
            if (timeout) begin
                m_axi_awvalid <= 1'b0;
                m_axi_wvalid  <= 1'b0;
                m_axi_bready  <= 1'b0;
                m_axi_arvalid <= 1'b0;
                m_axi_rready  <= 1'b0;
                txn_error     <= 1'b1;
                txn_done      <= 1'b1;
                state         <= DONE;
            end else
`endif
            case (state)
                IDLE: begin
                    // a pulse landing on the dispatch cycle is a fresh request, so it re-arms the flag
                    if (pend_wr) begin
                        pend_wr       <= init_write;
                        m_axi_wdata   <= 32'(count_in);
                        txn_error     <= 1'b0;
                        aw_done       <= 1'b0;
                        w_done        <= 1'b0;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR_REQ;
                    end else if (pend_rd) begin
                        pend_rd       <= init_read;
                        txn_error     <= 1'b0;
                        m_axi_arvalid <= 1'b1;
                        state         <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        m_axi_awvalid <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        m_axi_wvalid <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (m_axi_bvalid) begin
                        m_axi_bready <= 1'b0;
                        if (m_axi_bresp != 2'b00)
                            txn_error <= 1'b1;
                        txn_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                RD_REQ: begin
                    if (m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        state         <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (m_axi_rvalid) begin
                        m_axi_rready <= 1'b0;
                        if (m_axi_rresp == 2'b00) begin
                            start_value <= m_axi_rdata[COUNT_W-1:0];
                            start_load  <= 1'b1;
                        end else begin
                            txn_error <= 1'b1;
                        end
                        txn_done <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_count_axil_txn_master.sv
// tb/tb_count_axil_txn_master.sv - randomized bench for count_axil_txn_master
module tb_count_axil_txn_master;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        init_write = 1'b0;
    logic        init_read = 1'b0;
    logic [7:0]  count_in = '0;
    logic [7:0]  start_value;
    logic        start_load, txn_done, txn_error;
    logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    count_axil_txn_master dut (
        .aclk(aclk), .areset(areset), .init_write(init_write), .init_read(init_read),
        .count_in(count_in), .start_value(start_value), .start_load(start_load),
        .txn_done(txn_done), .txn_error(txn_error),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 aclk = ~aclk;

    int tests = 0;
    int fails = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // slave knobs, set by the stimulus between transactions
    int          aw_delay = 0, w_delay = 0, ar_delay = 0;
    logic [1:0]  inj_bresp = 2'b00, inj_rresp = 2'b00;
    logic [31:0] rd_word = '0;

    int          aw_cnt, w_cnt, ar_cnt;
    int          aw_beats = 0, w_beats = 0, ar_beats = 0, viol = 0;
    logic        got_aw, got_w, aw_hold, w_hold, ar_hold;
    logic [31:0] last_awaddr, last_wdata, last_araddr, held_wdata;
    logic [3:0]  last_wstrb;
    logic [2:0]  last_awprot, last_arprot;
    int          ev_log[$];

    always @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axi_awready <= 1'b0; m_axi_wready <= 1'b0; m_axi_arready <= 1'b0;
            m_axi_bvalid <= 1'b0; m_axi_bresp <= 2'b00;
            m_axi_rvalid <= 1'b0; m_axi_rresp <= 2'b00; m_axi_rdata <= '0;
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
            got_aw <= 1'b0; got_w <= 1'b0;
            aw_hold <= 1'b0; w_hold <= 1'b0; ar_hold <= 1'b0;
        end else begin
            // a valid seen without ready must still be there, with the same payload
            if (aw_hold && !m_axi_awvalid) viol <= viol + 1;
            if (ar_hold && !m_axi_arvalid) viol <= viol + 1;
            if (w_hold && (!m_axi_wvalid || m_axi_wdata !== held_wdata)) viol <= viol + 1;
            aw_hold    <= m_axi_awvalid && !m_axi_awready;
            w_hold     <= m_axi_wvalid && !m_axi_wready;
            ar_hold    <= m_axi_arvalid && !m_axi_arready;
            held_wdata <= m_axi_wdata;

            if (m_axi_awvalid && m_axi_awready) begin
                aw_beats <= aw_beats + 1; last_awaddr <= m_axi_awaddr; last_awprot <= m_axi_awprot;
                aw_cnt <= 0; m_axi_awready <= (aw_delay == 0); got_aw <= 1'b1;
                ev_log.push_back(1);
            end else if (m_axi_awvalid) begin
                aw_cnt <= aw_cnt + 1; m_axi_awready <= (aw_cnt + 1 >= aw_delay);
            end else begin
                aw_cnt <= 0; m_axi_awready <= (aw_delay == 0);
            end

            if (m_axi_wvalid && m_axi_wready) begin
                w_beats <= w_beats + 1; last_wdata <= m_axi_wdata; last_wstrb <= m_axi_wstrb;
                w_cnt <= 0; m_axi_wready <= (w_delay == 0); got_w <= 1'b1;
            end else if (m_axi_wvalid) begin
                w_cnt <= w_cnt + 1; m_axi_wready <= (w_cnt + 1 >= w_delay);
            end else begin
                w_cnt <= 0; m_axi_wready <= (w_delay == 0);
            end

            if (m_axi_bvalid && m_axi_bready) begin
                m_axi_bvalid <= 1'b0;
                ev_log.push_back(3);
            end else if (!m_axi_bvalid && (got_aw || (m_axi_awvalid && m_axi_awready))
                         && (got_w || (m_axi_wvalid && m_axi_wready))) begin
                m_axi_bvalid <= 1'b1; m_axi_bresp <= inj_bresp;
                got_aw <= 1'b0; got_w <= 1'b0;
            end

            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                ar_beats <= ar_beats + 1; last_araddr <= m_axi_araddr; last_arprot <= m_axi_arprot;
                ar_cnt <= 0; m_axi_arready <= (ar_delay == 0);
                m_axi_rvalid <= 1'b1; m_axi_rdata <= rd_word; m_axi_rresp <= inj_rresp;
                ev_log.push_back(4);
            end else if (m_axi_arvalid) begin
                ar_cnt <= ar_cnt + 1; m_axi_arready <= (ar_cnt + 1 >= ar_delay);
            end else begin
                ar_cnt <= 0; m_axi_arready <= (ar_delay == 0);
            end
        end
    end

    int done_cnt = 0, load_cnt = 0;
    always @(negedge aclk) begin
        if (txn_done) done_cnt++;
        if (start_load) load_cnt++;
    end

    // reference model state
    logic [7:0] exp_sv = 8'h00;

    task automatic wait_done(input int target, input int budget);
        int c = 0;
        while (done_cnt < target && c < budget) begin
            @(negedge aclk);
            c++;
        end
        if (done_cnt < target) check_eq("wait_done_timeout", 32'(done_cnt), 32'(target));
    endtask

    task automatic run_txn(input bit is_wr, input logic [7:0] cnt, input logic [31:0] word,
                           input logic [1:0] resp);
        int d0, l0, a0, w0, r0, exp_loads;
        logic exp_err;
        count_in = cnt; rd_word = word; inj_bresp = resp; inj_rresp = resp;
        @(negedge aclk);
        d0 = done_cnt; l0 = load_cnt; a0 = aw_beats; w0 = w_beats; r0 = ar_beats;
        if (is_wr) init_write = 1'b1; else init_read = 1'b1;
        @(negedge aclk);
        init_write = 1'b0; init_read = 1'b0;
        wait_done(d0 + 1, 400);
        repeat (3) @(negedge aclk);
        exp_err = (resp != 2'b00);
        exp_loads = 0;
        check_eq("done_once", 32'(done_cnt - d0), 32'd1);
        if (is_wr) begin
            check_eq("aw_beats", 32'(aw_beats - a0), 32'd1);
            check_eq("w_beats", 32'(w_beats - w0), 32'd1);
            check_eq("awaddr", last_awaddr, 32'h0000_0200);
            check_eq("awprot", 32'(last_awprot), 32'd0);
            check_eq("wdata", last_wdata, {24'h0, cnt});
            check_eq("wstrb", 32'(last_wstrb), 32'hF);
        end else begin
            check_eq("ar_beats", 32'(ar_beats - r0), 32'd1);
            check_eq("araddr", last_araddr, 32'h0000_0204);
            check_eq("arprot", 32'(last_arprot), 32'd0);
            if (!exp_err) begin
                exp_sv = word[7:0];
                exp_loads = 1;
            end
        end
        check_eq("start_load_cnt", 32'(load_cnt - l0), 32'(exp_loads));
        check_eq("start_value", 32'(start_value), 32'(exp_sv));
        check_eq("txn_error", 32'(txn_error), 32'(exp_err));
    endtask

    initial begin
        int lat, d0, i_b, i_ar, hi;
        logic [1:0] r;
        repeat (3) @(negedge aclk);
        check_eq("reset_outputs",
                 {24'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                  m_axi_rready, start_load, txn_done, txn_error}, 32'h0);
        check_eq("reset_start_value", 32'(start_value), 32'h0);
        areset = 1'b0;
        repeat (2) @(negedge aclk);

        // latency: pulse cycle counts as cycle 1, txn_done expected in cycle 5
        count_in = 8'h5A; inj_bresp = 2'b00;
        init_write = 1'b1;
        lat = 1;
        @(negedge aclk);
        init_write = 1'b0;
        while (!txn_done && lat < 50) begin
            lat++;
            @(negedge aclk);
        end
        check_eq("zero_wait_latency", 32'(lat + 1), 32'd5);
        check_eq("write_5A_data", last_wdata, 32'h0000_005A);
        repeat (2) @(negedge aclk);

        run_txn(1'b1, 8'h5A, 32'h0, 2'b00);
        run_txn(1'b0, 8'h00, 32'h0000_00AF, 2'b00);
        aw_delay = 1; w_delay = 4;
        run_txn(1'b1, 8'h3C, 32'h0, 2'b00);
        aw_delay = 0; w_delay = 0;
        run_txn(1'b0, 8'h00, 32'h0000_0011, 2'b10);
        run_txn(1'b1, 8'h77, 32'h0, 2'b00);

        for (int k = 0; k < 24; k++) begin
            aw_delay = $urandom_range(0, 5); w_delay = $urandom_range(0, 5);
            ar_delay = $urandom_range(0, 5);
            r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            run_txn(1'($urandom_range(0, 1)), 8'($urandom), $urandom, r);
        end
        aw_delay = 0; w_delay = 0; ar_delay = 0;

        // simultaneous requests: write must finish before AR is issued
        ev_log.delete();
        count_in = 8'h33; rd_word = 32'h0000_007C; inj_bresp = 2'b00; inj_rresp = 2'b00;
        d0 = done_cnt;
        init_write = 1'b1; init_read = 1'b1;
        @(negedge aclk);
        init_write = 1'b0; init_read = 1'b0;
        wait_done(d0 + 2, 400);
        repeat (3) @(negedge aclk);
        i_b = -1; i_ar = -1;
        foreach (ev_log[j]) begin
            if (ev_log[j] == 3 && i_b < 0) i_b = j;
            if (ev_log[j] == 4 && i_ar < 0) i_ar = j;
        end
        check_eq("simul_b_before_ar", 32'(i_b >= 0 && i_ar > i_b), 32'd1);
        check_eq("simul_two_done", 32'(done_cnt - d0), 32'd2);
        check_eq("simul_start_value", 32'(start_value), 32'h7C);
        exp_sv = 8'h7C;

        // repeat pulses while busy collapse into one extra request
        aw_delay = 10;
        d0 = done_cnt;
        init_write = 1'b1; @(negedge aclk); init_write = 1'b0;
        repeat (3) @(negedge aclk);
        init_write = 1'b1; @(negedge aclk); init_write = 1'b0;
        @(negedge aclk);
        init_write = 1'b1; @(negedge aclk); init_write = 1'b0;
        wait_done(d0 + 2, 400);
        repeat (30) @(negedge aclk);
        check_eq("collapse_done_cnt", 32'(done_cnt - d0), 32'd2);

        // reset in WR_REQ abandons the transaction at once
        aw_delay = 50; w_delay = 50;
        d0 = done_cnt;
        init_write = 1'b1; @(negedge aclk); init_write = 1'b0;
        repeat (3) @(negedge aclk);
        check_eq("pre_reset_valids", {30'h0, m_axi_awvalid, m_axi_wvalid}, 32'h3);
        areset = 1'b1;
        #1;
        check_eq("reset_mid_valids", {30'h0, m_axi_awvalid, m_axi_wvalid}, 32'h0);
        check_eq("reset_mid_start_value", 32'(start_value), 32'h0);
        exp_sv = 8'h00;
        aw_delay = 0; w_delay = 0;
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        repeat (60) @(negedge aclk);
        check_eq("reset_no_done", 32'(done_cnt - d0), 32'd0);

`ifdef TXN_TIMEOUT_EN
        ar_delay = 1000;
        d0 = done_cnt;
        hi = 0;
        init_read = 1'b1; @(negedge aclk); init_read = 1'b0;
        for (int c = 0; c < 400 && done_cnt == d0; c++) begin
            @(negedge aclk);
            if (m_axi_arvalid) hi++;
        end
        repeat (3) @(negedge aclk);
        check_eq("timeout_arvalid_cycles", 32'(hi), 32'd256);
        check_eq("timeout_error", 32'(txn_error), 32'd1);
        check_eq("timeout_done", 32'(done_cnt - d0), 32'd1);
        check_eq("timeout_start_value", 32'(start_value), 32'(exp_sv));
        ar_delay = 0;
        repeat (3) @(negedge aclk);
`endif

        run_txn(1'b1, 8'hC3, 32'h0, 2'b00);
        check_eq("handshake_stability", 32'(viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
